// File: rtl/tamagotchi_pkg.sv
// Shared constants for the tamagotchi front end: stat indices, hold-FSM states, saturation limit.
// Pure declarations; no logic, no latency, no flow control.
package tamagotchi_pkg;

  localparam int SALUD     = 0;
  localparam int ENERGIA   = 1;
  localparam int HAMBRE    = 2;
  localparam int DIVERSION = 3;

  localparam logic [2:0] SAT_CNT = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FIRED
  } hold_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stable-count debouncer, rise pulse in the first high cycle.
// Latency 2 + DB_CYCLES cycles from raw change to level change; no backpressure.
module btn_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level      <= 1'b0;
      rise       <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      rise   <= 1'b0;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
        stable_cnt <= '0;
        level      <= sync_b;
        rise       <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hold_timer.sv
// Measures whole seconds a debounced button is held (private second counter, saturating at 7).
// req pulses in the cycle count reaches HOLD_SEC; release clears count one cycle later; no backpressure.
module hold_timer
  import tamagotchi_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOLD_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level,
  input  logic       rise,
  output logic [2:0] count,
  output logic       req
);

  localparam int SW = $clog2(TICK_DIV);

  hold_state_t   state;
  hold_state_t   state_nxt;
  logic [SW-1:0] sub;
  logic [SW-1:0] sub_nxt;
  logic [2:0]    count_nxt;
  logic          req_nxt;
  logic          sec_done;

  assign sec_done = (sub == SW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sub   <= '0;
      count <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_nxt;
      sub   <= sub_nxt;
      count <= count_nxt;
      req   <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sub_nxt   = sub;
    count_nxt = count;
    req_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HOLD;
          sub_nxt   = '0;
          count_nxt = '0;
        end
      end
      HOLD, FIRED: begin
        if (!level) begin
          state_nxt = IDLE;
          sub_nxt   = '0;
          count_nxt = '0;
        end else begin
          // Seconds are measured from the press, independent of the shared tick.
          sub_nxt = sec_done ? '0 : sub + 1'b1;
          if (sec_done) begin
            if (count != SAT_CNT) count_nxt = count + 1'b1;
            if (state == HOLD && count_nxt == 3'(HOLD_SEC)) begin
              state_nxt = FIRED;
              req_nxt   = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        sub_nxt   = '0;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/tamagotchi_input_sched.sv
// Button front end, 1 s time base, hold timers, round-robin care arbiter and decay-strobe scheduler.
// Grants/strobes are registered one-hot pulses one cycle after their cause; pending bits queue contention, no backpressure.
module tamagotchi_input_sched
  import tamagotchi_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DB_CYCLES   = 500_000,
  parameter int HOLD_SEC    = 5,
  parameter int P_SALUD     = 120,
  parameter int P_ENERGIA   = 100,
  parameter int P_HAMBRE    = 70,
  parameter int P_DIVERSION = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_care,
  input  logic       btn_reset,
  input  logic       btn_test,
  input  logic       test_mode_i,
  output logic       tick_1s,
  output logic [3:0] care_grant,
  output logic [1:0] sel,
  output logic [2:0] count_reset,
  output logic [2:0] count_test,
  output logic       reset_req,
  output logic       test_req,
  output logic [3:0] decay_strobe
);

  localparam int P_MAX_A = (P_SALUD > P_ENERGIA) ? P_SALUD : P_ENERGIA;
  localparam int P_MAX_B = (P_HAMBRE > P_DIVERSION) ? P_HAMBRE : P_DIVERSION;
  localparam int P_MAX   = (P_MAX_A > P_MAX_B) ? P_MAX_A : P_MAX_B;
  localparam int SEC_W   = ($clog2(P_MAX) < 1) ? 1 : $clog2(P_MAX);
  localparam int DIV_W   = $clog2(TICK_DIV);

  logic [3:0] care_level_unused;
  logic [3:0] care_rise;
  logic       rst_level;
  logic       rst_rise;
  logic       tst_level;
  logic       tst_rise;

  for (genvar g = 0; g < 4; g++) begin : g_care_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_care[g]),
      .level (care_level_unused[g]),
      .rise  (care_rise[g])
    );
  end

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_reset),
    .level (rst_level),
    .rise  (rst_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_test (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_test),
    .level (tst_level),
    .rise  (tst_rise)
  );

  hold_timer #(.TICK_DIV(TICK_DIV), .HOLD_SEC(HOLD_SEC)) u_hold_reset (
    .clk   (clk),
    .rst_n (rst_n),
    .level (rst_level),
    .rise  (rst_rise),
    .count (count_reset),
    .req   (reset_req)
  );

  hold_timer #(.TICK_DIV(TICK_DIV), .HOLD_SEC(HOLD_SEC)) u_hold_test (
    .clk   (clk),
    .rst_n (rst_n),
    .level (tst_level),
    .rise  (tst_rise),
    .count (count_test),
    .req   (test_req)
  );

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick_1s <= 1'b0;
    end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      tick_1s <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick_1s <= 1'b0;
    end
  end

  // Care arbiter: round-robin over pending presses, search starts just after the last winner.
  logic [3:0] care_pend;
  logic [3:0] care_req;
  logic [3:0] grant_nxt;
  logic [1:0] ptr;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  always_comb begin
    care_req  = care_pend | care_rise;
    grant_nxt = '0;
    grant_idx = ptr;
    cand      = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (grant_nxt == 4'b0 && care_req[cand]) begin
        grant_nxt[cand] = 1'b1;
        grant_idx       = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      care_pend  <= '0;
      care_grant <= '0;
      ptr        <= 2'd3;
      sel        <= '0;
    end else if (reset_req) begin
      care_pend  <= '0;
      care_grant <= '0;
      ptr        <= 2'd3;
    end else begin
      care_grant <= grant_nxt;
      care_pend  <= care_req & ~grant_nxt;
      if (grant_nxt != 4'b0) begin
        ptr <= grant_idx;
        sel <= grant_idx;
      end
    end
  end

  function automatic logic [SEC_W-1:0] last_sec(input int i);
    case (i)
      SALUD:     return SEC_W'(P_SALUD - 1);
      ENERGIA:   return SEC_W'(P_ENERGIA - 1);
      HAMBRE:    return SEC_W'(P_HAMBRE - 1);
      DIVERSION: return SEC_W'(P_DIVERSION - 1);
      default:   return '0;
    endcase
  endfunction

  logic [3:0][SEC_W-1:0] sec_cnt;
  logic [3:0]            expire;
  logic [3:0]            decay_pend;
  logic [3:0]            decay_req;
  logic [3:0]            strobe_nxt;
  logic                  advance;

  assign advance = tick_1s & ~test_mode_i;

  // Lowest pending index wins, so simultaneous expiries drain in index order.
  always_comb begin
    expire = '0;
    for (int i = 0; i < 4; i++) begin
      expire[i] = advance && (sec_cnt[i] == last_sec(i));
    end
    decay_req  = decay_pend | expire;
    strobe_nxt = decay_req & (~decay_req + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || reset_req) begin
      sec_cnt      <= '0;
      decay_pend   <= '0;
      decay_strobe <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (advance) sec_cnt[i] <= expire[i] ? '0 : sec_cnt[i] + 1'b1;
      end
      decay_pend   <= decay_req & ~strobe_nxt;
      decay_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_tamagotchi_input_sched.sv
// Directed bench for tamagotchi_input_sched with small timing parameters (tick 10, debounce 3, periods 4/3/2/2).
module tb_tamagotchi_input_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_care = 4'b0;
  logic       btn_reset = 1'b0;
  logic       btn_test = 1'b0;
  logic       test_mode_i = 1'b0;
  logic       tick_1s;
  logic [3:0] care_grant;
  logic [1:0] sel;
  logic [2:0] count_reset;
  logic [2:0] count_test;
  logic       reset_req;
  logic       test_req;
  logic [3:0] decay_strobe;

  int compared = 0;
  int failed = 0;
  int cyc = 0;
  int nz;

  tamagotchi_input_sched #(
    .TICK_DIV(10), .DB_CYCLES(3), .HOLD_SEC(5),
    .P_SALUD(4), .P_ENERGIA(3), .P_HAMBRE(2), .P_DIVERSION(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_care     (btn_care),
    .btn_reset    (btn_reset),
    .btn_test     (btn_test),
    .test_mode_i  (test_mode_i),
    .tick_1s      (tick_1s),
    .care_grant   (care_grant),
    .sel          (sel),
    .count_reset  (count_reset),
    .count_test   (count_test),
    .reset_req    (reset_req),
    .test_req     (test_req),
    .decay_strobe (decay_strobe)
  );

  always #5 clk = ~clk;

  // Edges seen with rst_n high since the last reset.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input int n, input int mode, output int cnt);
    cnt = 0;
    repeat (n) begin
      step(1);
      case (mode)
        0:       if (care_grant != 4'b0) cnt++;
        1:       if (decay_strobe != 4'b0) cnt++;
        2:       if (reset_req) cnt++;
        default: if (count_test != 3'd0) cnt++;
      endcase
    end
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_tick", tick_1s, 0);
    chk("rst_grant", care_grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_count_reset", count_reset, 0);
    chk("rst_count_test", count_test, 0);
    chk("rst_reset_req", reset_req, 0);
    chk("rst_test_req", test_req, 0);
    chk("rst_strobe", decay_strobe, 0);
    rst_n = 1'b1;

    // First tick TICK_DIV cycles after release
    goto(9);   chk("tick_before", tick_1s, 0);
    goto(10);  chk("tick_first", tick_1s, 1);
    goto(11);  chk("tick_single", tick_1s, 0);

    // Decay schedule: strobes land the cycle after each tick
    goto(20);  chk("dec_t20", decay_strobe, 4'b0000);
    goto(21);  chk("dec_t21", decay_strobe, 4'b0100);
    goto(22);  chk("dec_t22", decay_strobe, 4'b1000);
    goto(23);  chk("dec_t23", decay_strobe, 4'b0000);
    goto(31);  chk("dec_t31", decay_strobe, 4'b0010);
    goto(41);  chk("dec_t41", decay_strobe, 4'b0001);
    goto(42);  chk("dec_t42", decay_strobe, 4'b0100);
    goto(43);  chk("dec_t43", decay_strobe, 4'b1000);
    goto(121); chk("dec_all0", decay_strobe, 4'b0001);
    goto(122); chk("dec_all1", decay_strobe, 4'b0010);
    goto(123); chk("dec_all2", decay_strobe, 4'b0100);
    goto(124); chk("dec_all3", decay_strobe, 4'b1000);
    goto(125); chk("dec_all_end", decay_strobe, 4'b0000);

    // Freeze for ticks 14..18, then resume as if tick 19 were tick 14
    goto(135);
    test_mode_i = 1'b1;
    quiet(50, 1, nz);
    chk("freeze_no_strobe", nz, 0);
    test_mode_i = 1'b0;
    goto(190); chk("res_t190", decay_strobe, 4'b0000);
    goto(191); chk("res_t191", decay_strobe, 4'b0100);
    goto(192); chk("res_t192", decay_strobe, 4'b1000);
    goto(201); chk("res_t201", decay_strobe, 4'b0010);
    goto(211); chk("res_t211", decay_strobe, 4'b0001);
    goto(212); chk("res_t212", decay_strobe, 4'b0100);
    goto(213); chk("res_t213", decay_strobe, 4'b1000);

    // Care: 2-cycle glitch ignored, long press granted exactly once
    btn_care = 4'b0100;
    step(2);
    btn_care = 4'b0000;
    quiet(12, 0, nz);
    chk("glitch_no_grant", nz, 0);
    btn_care = 4'b0100;
    step(5);   chk("press_pre_grant", care_grant, 4'b0000);
    step(1);   chk("press_grant", care_grant, 4'b0100);
    chk("press_sel", sel, 2);
    quiet(10, 0, nz);
    chk("press_held_no_regrant", nz, 0);
    btn_care = 4'b0000;
    step(8);

    // Reset-button hold: seconds from the press, req at 5, saturate at 7
    btn_reset = 1'b1;
    step(6);   chk("hold_c6", count_reset, 0);
    step(9);   chk("hold_c15", count_reset, 0);
    step(1);   chk("hold_c16", count_reset, 1);
    step(39);  chk("hold_c55", count_reset, 4);
    chk("hold_req_early", reset_req, 0);
    step(1);   chk("hold_c56", count_reset, 5);
    chk("hold_req", reset_req, 1);
    step(1);   chk("hold_req_single", reset_req, 0);
    chk("hold_c57", count_reset, 5);
    quiet(29, 2, nz);
    chk("hold_no_second_req", nz, 0);
    chk("hold_c86", count_reset, 7);
    step(20);  chk("hold_sat", count_reset, 7);
    chk("hold_test_req_idle", test_req, 0);
    btn_reset = 1'b0;
    step(5);   chk("rel_pre", count_reset, 7);
    step(1);   chk("rel_cleared", count_reset, 0);
    step(4);

    // Simultaneous care presses after reset_req restored the pointer to 3
    btn_care = 4'b1011;
    step(5);   chk("rr_pre", care_grant, 4'b0000);
    step(1);   chk("rr_g0", care_grant, 4'b0001);
    chk("rr_s0", sel, 0);
    step(1);   chk("rr_g1", care_grant, 4'b0010);
    chk("rr_s1", sel, 1);
    step(1);   chk("rr_g2", care_grant, 4'b1000);
    chk("rr_s2", sel, 3);
    step(1);   chk("rr_done", care_grant, 4'b0000);
    chk("rr_sel_end", sel, 3);
    btn_care = 4'b0000;
    step(8);

    // rst_n mid-hold with care presses about to be granted
    btn_test = 1'b1;
    step(32);
    btn_care = 4'b1100;
    step(4);   chk("mid_count_test", count_test, 3);
    step(1);   chk("mid_no_grant_yet", care_grant, 4'b0000);
    rst_n = 1'b0;
    btn_test = 1'b0;
    btn_care = 4'b0000;
    step(1);
    chk("mid_rst_grant", care_grant, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_count_test", count_test, 0);
    chk("mid_rst_strobe", decay_strobe, 0);
    chk("mid_rst_tick", tick_1s, 0);
    rst_n = 1'b1;
    quiet(20, 0, nz);
    chk("post_rst_no_grant", nz, 0);
    quiet(10, 3, nz);
    chk("post_rst_count_test_zero", nz, 0);
    btn_test = 1'b1;
    step(15);  chk("fresh_c15", count_test, 0);
    step(1);   chk("fresh_c16", count_test, 1);
    btn_test = 1'b0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
